// File: rtl/conv3x3_pkg.sv
// Shared types and constants for the 3x3 streaming gradient convolver.
//   kernel_mode_e : kernel selection (Sobel 1,2,1 / Scharr 3,10,3)
//   out_w()       : signed gradient width for a given pixel width
//   *_K_EDGE/MID  : kernel coefficients for the outer and centre taps
package conv3x3_pkg;

   typedef enum logic {
      KERN_SOBEL  = 1'b0,
      KERN_SCHARR = 1'b1
   } kernel_mode_e;

   localparam int SOBEL_K_EDGE  = 1;
   localparam int SOBEL_K_MID   = 2;
   localparam int SCHARR_K_EDGE = 3;
   localparam int SCHARR_K_MID  = 10;

   // |g| <= 16*(2^w-1) needs w+4 magnitude bits plus a sign bit.
   function automatic int out_w(input int width);
      return width + 5;
   endfunction

endpackage

// File: rtl/conv3x3_linebuf.sv
// Two-line buffer for the 3x3 convolver.
// Ports:
//   clk_i     clock
//   en_i      advance (pixel accepted); reads and writes happen only then
//   col_i     column of the pixel being accepted
//   data_i    pixel being accepted (row r)
//   row_m1_o  pixel at row r-1, column col_i
//   row_m2_o  pixel at row r-2, column col_i
// Contents are never cleared; the consumer only uses them once two full
// rows of the current frame have passed through.
module conv3x3_linebuf
   import conv3x3_pkg::*;
#(
   parameter int WIDTH_P = 8,
   parameter int IMG_W_P = 16,
   localparam int CW = (IMG_W_P > 1) ? $clog2(IMG_W_P) : 1
) (
   input  logic               clk_i,
   input  logic               en_i,
   input  logic [CW-1:0]      col_i,
   input  logic [WIDTH_P-1:0] data_i,
   output logic [WIDTH_P-1:0] row_m1_o,
   output logic [WIDTH_P-1:0] row_m2_o
);

   logic [WIDTH_P-1:0] row_m1_q [IMG_W_P];
   logic [WIDTH_P-1:0] row_m2_q [IMG_W_P];

   // Asynchronous read: the window needs the column above the incoming
   // pixel in the same cycle it is accepted.
   assign row_m1_o = row_m1_q[col_i];
   assign row_m2_o = row_m2_q[col_i];

   // The slot for this column moves down one row: r-1 becomes r-2 and the
   // new pixel becomes r-1 for the next line.
   always_ff @(posedge clk_i) begin
      if (en_i) begin
         row_m1_q[col_i] <= data_i;
         row_m2_q[col_i] <= row_m1_q[col_i];
      end
   end

endmodule

// File: rtl/conv3x3_stream.sv
// Streaming 3x3 gradient convolver (Sobel / Scharr).
// Consumes a raster pixel stream, tracks row/column, and emits signed Gx/Gy
// only for interior pixels (centre row 1..IMG_H_P-2, col 1..IMG_W_P-2).
// Ports:
//   clk_i, rstn_i      clock, asynchronous active-low reset
//   valid_i/ready_o    input handshake, data_i pixel, sof_i marks pixel (0,0)
//   mode_i             kernel select, latched on an accepted sof_i
//   valid_o/ready_i    output handshake
//   gx_o, gy_o         signed gradients (OUT_W = WIDTH_P+5)
//   eol_o, eof_o       last output of a line / of the frame
//   mag_o              |gx|+|gy| saturated (only with CONV3X3_MAG_EN defined)
// Build option: CONV3X3_MAG_EN adds the magnitude output.
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. valid_o and all output data are registered and held unchanged
// while valid_o & ~ready_i. ready_o = ~valid_o | ready_i, so the input is
// only stalled when the single output register is full and not draining.
module conv3x3_stream
   import conv3x3_pkg::*;
#(
   parameter int WIDTH_P = 8,
   parameter int IMG_W_P = 16,
   parameter int IMG_H_P = 16,
   localparam int OUT_W = out_w(WIDTH_P)
) (
   input  logic             clk_i,
   input  logic             rstn_i,
   input  logic             valid_i,
   output logic             ready_o,
   input  logic [WIDTH_P-1:0] data_i,
   input  logic             sof_i,
   input  logic             mode_i,
   output logic             valid_o,
   input  logic             ready_i,
   output logic [OUT_W-1:0] gx_o,
   output logic [OUT_W-1:0] gy_o,
   output logic             eol_o,
   output logic             eof_o
`ifdef CONV3X3_MAG_EN
   ,
   output logic [OUT_W-1:0] mag_o
`endif
);

   localparam int CW = (IMG_W_P > 1) ? $clog2(IMG_W_P) : 1;
   localparam int RW = (IMG_H_P > 1) ? $clog2(IMG_H_P) : 1;
   localparam logic [CW-1:0] COL_LAST = CW'(IMG_W_P - 1);
   localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H_P - 1);

   logic accept;
   logic [CW-1:0] col_q, col_d, col_cur;
   logic [RW-1:0] row_q, row_d, row_cur;
   kernel_mode_e  mode_q, mode_d;

   // Window columns c-2 (index 0) and c-1 (index 1); rows 0=r-2 .. 2=r.
   logic [WIDTH_P-1:0] win_q [3][2];
   logic [WIDTH_P-1:0] win_d [3][2];
   logic [WIDTH_P-1:0] new_col [3];
   logic [WIDTH_P-1:0] lb_m1, lb_m2;

   logic emit, eol_cur, eof_cur;
   logic signed [OUT_W-1:0] k_edge, k_mid, gx_calc, gy_calc;

   logic             valid_q, valid_d;
   logic [OUT_W-1:0] gx_q, gx_d, gy_q, gy_d;
   logic             eol_q, eol_d, eof_q, eof_d;

   assign ready_o = ~valid_q | ready_i;
   assign accept  = valid_i & ready_o;

   // sof_i overrides the counters so this pixel is (0,0) regardless of
   // where the previous frame stopped.
   assign col_cur = sof_i ? '0 : col_q;
   assign row_cur = sof_i ? '0 : row_q;

   conv3x3_linebuf #(
      .WIDTH_P (WIDTH_P),
      .IMG_W_P (IMG_W_P)
   ) u_linebuf (
      .clk_i    (clk_i),
      .en_i     (accept),
      .col_i    (col_cur),
      .data_i   (data_i),
      .row_m1_o (lb_m1),
      .row_m2_o (lb_m2)
   );

   assign new_col[0] = lb_m2;
   assign new_col[1] = lb_m1;
   assign new_col[2] = data_i;

   // Rows r-2 and the columns c-2 are only meaningful from (2,2) onward;
   // everything earlier in a line or frame is suppressed here.
   assign emit    = (row_cur >= RW'(2)) && (col_cur >= CW'(2));
   assign eol_cur = (col_cur == COL_LAST);
   assign eof_cur = eol_cur && (row_cur == ROW_LAST);

   assign k_edge = (mode_q == KERN_SCHARR) ? OUT_W'(SCHARR_K_EDGE) : OUT_W'(SOBEL_K_EDGE);
   assign k_mid  = (mode_q == KERN_SCHARR) ? OUT_W'(SCHARR_K_MID)  : OUT_W'(SOBEL_K_MID);

   function automatic logic signed [OUT_W-1:0] zx(input logic [WIDTH_P-1:0] p);
      return $signed({{(OUT_W-WIDTH_P){1'b0}}, p});
   endfunction

   // Right minus left column, and bottom minus top row, over the window
   // formed by the two stored columns plus the column arriving now.
   always_comb begin
      gx_calc = k_edge * (zx(new_col[0]) - zx(win_q[0][0]))
              + k_mid  * (zx(new_col[1]) - zx(win_q[1][0]))
              + k_edge * (zx(new_col[2]) - zx(win_q[2][0]));
      gy_calc = k_edge * (zx(new_col[2]) - zx(win_q[0][0]))
              + k_mid  * (zx(win_q[2][1]) - zx(win_q[0][1]))
              + k_edge * (zx(new_col[2]) - zx(new_col[0]))
              - k_edge * (zx(new_col[2]) - zx(win_q[2][0]));
   end

   // Counters, mode latch and window shift.
   always_comb begin
      col_d  = col_q;
      row_d  = row_q;
      mode_d = mode_q;
      win_d  = win_q;
      if (accept) begin
         if (sof_i) begin
            mode_d = mode_i ? KERN_SCHARR : KERN_SOBEL;
         end
         if (col_cur == COL_LAST) begin
            col_d = '0;
            row_d = (row_cur == ROW_LAST) ? '0 : row_cur + RW'(1);
         end else begin
            col_d = col_cur + CW'(1);
            row_d = row_cur;
         end
         for (int i = 0; i < 3; i++) begin
            win_d[i][0] = sof_i ? '0 : win_q[i][1];
            win_d[i][1] = new_col[i];
         end
      end
   end

   // Output register: load on an accepted interior pixel, drop valid once
   // the held result has been taken and nothing new replaces it.
   always_comb begin
      valid_d = valid_q;
      gx_d    = gx_q;
      gy_d    = gy_q;
      eol_d   = eol_q;
      eof_d   = eof_q;
      if (accept) begin
         valid_d = emit;
         if (emit) begin
            gx_d  = gx_calc;
            gy_d  = gy_calc;
            eol_d = eol_cur;
            eof_d = eof_cur;
         end
      end else if (ready_i) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         col_q   <= '0;
         row_q   <= '0;
         mode_q  <= KERN_SOBEL;
         win_q   <= '{default: '0};
         valid_q <= 1'b0;
         gx_q    <= '0;
         gy_q    <= '0;
         eol_q   <= 1'b0;
         eof_q   <= 1'b0;
      end else begin
         col_q   <= col_d;
         row_q   <= row_d;
         mode_q  <= mode_d;
         win_q   <= win_d;
         valid_q <= valid_d;
         gx_q    <= gx_d;
         gy_q    <= gy_d;
         eol_q   <= eol_d;
         eof_q   <= eof_d;
      end
   end

   assign valid_o = valid_q;
   assign gx_o    = gx_q;
   assign gy_o    = gy_q;
   assign eol_o   = eol_q;
   assign eof_o   = eof_q;

`ifdef CONV3X3_MAG_EN
   logic [OUT_W-1:0] abs_gx, abs_gy, mag_calc, mag_q, mag_d;
   logic [OUT_W:0]   mag_sum;

   always_comb begin
      abs_gx   = gx_calc[OUT_W-1] ? OUT_W'(-gx_calc) : OUT_W'(gx_calc);
      abs_gy   = gy_calc[OUT_W-1] ? OUT_W'(-gy_calc) : OUT_W'(gy_calc);
      mag_sum  = {1'b0, abs_gx} + {1'b0, abs_gy};
      mag_calc = mag_sum[OUT_W] ? '1 : mag_sum[OUT_W-1:0];
      mag_d    = mag_q;
      if (accept && emit) begin
         mag_d = mag_calc;
      end
   end

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         mag_q <= '0;
      end else begin
         mag_q <= mag_d;
      end
   end

   assign mag_o = mag_q;
`endif

endmodule

// File: tb/tb_conv3x3_stream.sv
module tb_conv3x3_stream;

   localparam int WP = 8;
   localparam int IW = 8;
   localparam int IH = 6;
   localparam int OW = 13;
   localparam int EW = 3 * OW + 2;

   logic          clk = 1'b0;
   logic          rstn_i = 1'b1;
   logic          valid_i = 1'b0;
   logic          ready_o;
   logic [WP-1:0] data_i = '0;
   logic          sof_i = 1'b0;
   logic          mode_i = 1'b0;
   logic          valid_o;
   logic          ready_i = 1'b1;
   logic [OW-1:0] gx_o, gy_o;
   logic          eol_o, eof_o;
`ifdef CONV3X3_MAG_EN
   logic [OW-1:0] mag_o;
`endif

   always #5 clk = ~clk;

   conv3x3_stream #(
      .WIDTH_P (WP),
      .IMG_W_P (IW),
      .IMG_H_P (IH)
   ) dut (
      .clk_i   (clk),
      .rstn_i  (rstn_i),
      .valid_i (valid_i),
      .ready_o (ready_o),
      .data_i  (data_i),
      .sof_i   (sof_i),
      .mode_i  (mode_i),
      .valid_o (valid_o),
      .ready_i (ready_i),
      .gx_o    (gx_o),
      .gy_o    (gy_o),
      .eol_o   (eol_o),
`ifdef CONV3X3_MAG_EN
      .mag_o   (mag_o),
`endif
      .eof_o   (eof_o)
   );

   int total = 0;
   int bad = 0;
   int vcount = 0;

   // Expected queue: {gx, gy, eol, eof, mag}
   logic [EW-1:0] exp_q[$];
   logic [OW-1:0] got_gx[$], got_gy[$], got_mag[$];
   logic          got_eol[$], got_eof[$];

   int src[IH][IW];
   int img[IH][IW];
   int m_r = 0, m_c = 0;
   bit m_mode = 1'b0;

   task automatic check(input string tag, input logic [OW-1:0] obs, input logic [OW-1:0] expv);
      total++;
      assert (obs === expv) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
      end
   endtask

   // Reference model: position follows the raster rules, gradients are the
   // plain kernel sums over the stored frame.
   function automatic void model_accept(input int d, input bit sof, input bit md);
      int k[3];
      int gx, gy, mag;
      bit eol, eof;
      if (sof) begin
         m_r = 0;
         m_c = 0;
         m_mode = md;
      end
      img[m_r][m_c] = d;
      if (m_r >= 2 && m_c >= 2) begin
         if (m_mode) begin
            k[0] = 3; k[1] = 10; k[2] = 3;
         end else begin
            k[0] = 1; k[1] = 2; k[2] = 1;
         end
         gx = 0;
         gy = 0;
         for (int i = 0; i < 3; i++) begin
            gx += k[i] * (img[m_r-2+i][m_c] - img[m_r-2+i][m_c-2]);
            gy += k[i] * (img[m_r][m_c-2+i] - img[m_r-2][m_c-2+i]);
         end
         mag = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
         if (mag > 8191) mag = 8191;
         eol = (m_c == IW - 1);
         eof = eol && (m_r == IH - 1);
         exp_q.push_back({OW'(gx), OW'(gy), eol, eof, OW'(mag)});
      end
      if (m_c == IW - 1) begin
         m_c = 0;
         m_r = (m_r == IH - 1) ? 0 : m_r + 1;
      end else begin
         m_c++;
      end
   endfunction

   // Scoreboard: a transfer is seen at the negedge before the edge that
   // completes it.
   always @(negedge clk) begin
      logic [EW-1:0] e;
      if (rstn_i && valid_o) vcount++;
      if (rstn_i && valid_o && ready_i) begin
         got_gx.push_back(gx_o);
         got_gy.push_back(gy_o);
         got_eol.push_back(eol_o);
         got_eof.push_back(eof_o);
`ifdef CONV3X3_MAG_EN
         got_mag.push_back(mag_o);
`endif
         check("output_expected", OW'(exp_q.size() > 0), 1);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("gx", gx_o, e[EW-1 -: OW]);
            check("gy", gy_o, e[EW-1-OW -: OW]);
            check("eol", OW'(eol_o), OW'(e[OW+1]));
            check("eof", OW'(eof_o), OW'(e[OW]));
`ifdef CONV3X3_MAG_EN
            check("mag", mag_o, e[OW-1:0]);
`endif
         end
      end
   end

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send(input int d, input bit sof, input bit md);
      int n;
      valid_i = 1'b1;
      data_i  = WP'(d);
      sof_i   = sof;
      mode_i  = md;
      n = 0;
      @(negedge clk);
      while (!ready_o && n < 100) begin
         n++;
         @(negedge clk);
      end
      check("accept_timeout", OW'(n < 100), 1);
      if (ready_o) begin
         @(posedge clk);
         model_accept(d, sof, md);
      end
      #1;
      valid_i = 1'b0;
      sof_i   = 1'b0;
   endtask

   task automatic clear_got();
      got_gx.delete(); got_gy.delete(); got_mag.delete();
      got_eol.delete(); got_eof.delete();
   endtask

   task automatic run_frame(input bit md);
      clear_got();
      for (int r = 0; r < IH; r++)
         for (int c = 0; c < IW; c++)
            send(src[r][c], (r == 0 && c == 0), md);
      idle(4);
      check("exp_drained", OW'(exp_q.size()), 0);
      check("out_count", OW'(got_gx.size()), 24);
   endtask

   function automatic int count_val(input logic [OW-1:0] q[$], input logic [OW-1:0] v);
      int n = 0;
      foreach (q[i]) if (q[i] == v) n++;
      return n;
   endfunction

   function automatic int count_ones(input logic q[$]);
      int n = 0;
      foreach (q[i]) if (q[i]) n++;
      return n;
   endfunction

   task automatic fill_vert();
      for (int r = 0; r < IH; r++)
         for (int c = 0; c < IW; c++)
            src[r][c] = (c >= 4) ? 255 : 0;
   endtask

   task automatic fill_random();
      for (int r = 0; r < IH; r++)
         for (int c = 0; c < IW; c++)
            src[r][c] = int'($urandom_range(0, 255));
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [OW-1:0] hg, hy;
      bit md;

      // Reset
      #2 rstn_i = 1'b0;
      idle(3);
      @(negedge clk);
      check("rst_valid_o", OW'(valid_o), 0);
      check("rst_gx_o", gx_o, 0);
      check("rst_gy_o", gy_o, 0);
      check("rst_eol_o", OW'(eol_o), 0);
      check("rst_eof_o", OW'(eof_o), 0);
      check("rst_ready_o", OW'(ready_o), 1);
      @(posedge clk); #1 rstn_i = 1'b1;
      idle(2);

      // 1: vertical edge, Sobel
      fill_vert();
      run_frame(1'b0);
      check("t1_gx1020_count", OW'(count_val(got_gx, 13'd1020)), 8);
      check("t1_gx0_count", OW'(count_val(got_gx, 13'd0)), 16);
      check("t1_gy0_count", OW'(count_val(got_gy, 13'd0)), 24);
      check("t1_eol_count", OW'(count_ones(got_eol)), 4);
      check("t1_eof_count", OW'(count_ones(got_eof)), 1);
      check("t1_eof_last", OW'(got_eof[23]), 1);

      // 2: Scharr, vertical then horizontal edge
      run_frame(1'b1);
      check("t2_gx4080_count", OW'(count_val(got_gx, 13'd4080)), 8);
      for (int r = 0; r < IH; r++)
         for (int c = 0; c < IW; c++)
            src[r][c] = (r >= 3) ? 255 : 0;
      run_frame(1'b1);
      check("t2h_gy4080_count", OW'(count_val(got_gy, 13'd4080)), 12);
      check("t2h_gx0_count", OW'(count_val(got_gx, 13'd0)), 24);

      // 3: random frame with a 5-cycle downstream stall mid row 3
      fill_random();
      md = 1'($urandom_range(0, 1));
      clear_got();
      for (int r = 0; r < IH; r++)
         for (int c = 0; c < IW; c++) begin
            if (r == 3 && c == 4) begin
               ready_i = 1'b0;
               valid_i = 1'b1;
               data_i  = WP'(src[r][c]);
               @(negedge clk);
               hg = gx_o;
               hy = gy_o;
               check("t3_stall_valid", OW'(valid_o), 1);
               check("t3_stall_ready", OW'(ready_o), 0);
               for (int s = 0; s < 4; s++) begin
                  @(negedge clk);
                  check("t3_stall_ready", OW'(ready_o), 0);
                  check("t3_hold_gx", gx_o, hg);
                  check("t3_hold_gy", gy_o, hy);
               end
               @(posedge clk); #1 ready_i = 1'b1;
            end
            send(src[r][c], (r == 0 && c == 0), md);
         end
      idle(4);
      check("t3_exp_drained", OW'(exp_q.size()), 0);
      check("t3_out_count", OW'(got_gx.size()), 24);

      // 4: sof reasserted at pixel (3,5) with a mode change
      fill_random();
      for (int r = 0; r < IH; r++)
         for (int c = 0; c < IW; c++)
            if (r < 3 || (r == 3 && c < 5))
               send(src[r][c], (r == 0 && c == 0), 1'b0);
      fill_random();
      send(src[0][0], 1'b1, 1'b1);
      vcount = 0;
      for (int i = 1; i < 2 * IW + 2; i++)
         send(src[i / IW][i % IW], 1'b0, 1'b1);
      check("t4_no_early_valid", OW'(vcount), 0);
      check("t4_valid_low", OW'(valid_o), 0);
      clear_got();
      for (int i = 2 * IW + 2; i < IW * IH; i++)
         send(src[i / IW][i % IW], 1'b0, 1'b1);
      idle(4);
      check("t4_exp_drained", OW'(exp_q.size()), 0);
      check("t4_out_count", OW'(got_gx.size()), 24);

      // 5: asynchronous reset mid-frame
      fill_random();
      for (int i = 0; i < 2 * IW + 4; i++)
         send(src[i / IW][i % IW], (i == 0), 1'b0);
      check("t5_valid_before", OW'(valid_o), 1);
      #2 rstn_i = 1'b0;
      #1;
      check("t5_rst_valid", OW'(valid_o), 0);
      check("t5_rst_gx", gx_o, 0);
      check("t5_rst_gy", gy_o, 0);
      exp_q.delete();
      m_r = 0;
      m_c = 0;
      idle(2);
      rstn_i = 1'b1;
      idle(1);
      fill_random();
      run_frame(1'($urandom_range(0, 1)));

`ifdef CONV3X3_MAG_EN
      // 6: magnitude output
      for (int r = 0; r < IH; r++)
         for (int c = 0; c < IW; c++)
            src[r][c] = 128;
      run_frame(1'b0);
      check("t6_mag0_count", OW'(count_val(got_mag, 13'd0)), 24);
      fill_vert();
      run_frame(1'b0);
      check("t6_mag1020_count", OW'(count_val(got_mag, 13'd1020)), 8);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
